dmem_access_ctrl: RTL and testbench

- Sequences multi-cycle data-memory accesses for the MEM stage of the 5-stage pipeline.
- Issues a req/ack transaction to the data memory and holds the pipeline while the transaction is outstanding.
- While stalled, forces a bubble into MEM/WB so write-back never repeats an instruction.
- Reports a sticky timeout error and a saturating count of stall cycles for performance debug.

---
 rtl/dmem_ctrl_pkg.sv | 20 ++
 rtl/dmem_access_ctrl_sat_counter.sv | 42 ++++
 rtl/dmem_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared types and constants for the data-memory access controller
//
// Purpose: state encoding, default timeout and datapath width used by
// dmem_access_ctrl and its helpers.
// Contents:
//   DATA_W          address / data width of the memory port
//   TIMEOUT_DEFAULT default number of WAIT cycles before an access is abandoned
//   state_e         access sequencer states
package dmem_ctrl_pkg;

  localparam int DATA_W          = 32;
  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_access_ctrl_sat_counter.sv
// rtl/dmem_access_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
//
// Purpose: counts enabled cycles and holds at all-ones instead of wrapping.
// Ports:
//   clk_i  in  clock, rising edge
//   rst_i  in  asynchronous active-low clear
//   clr_i  in  synchronous clear, wins over en_i
//   en_i   in  count enable
//   cnt_o  out current count (W bits)
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage sequencer for multi-cycle data-memory accesses
//
// Purpose: turns a load/store in MEM into a req/ack memory transaction, stalls
// the pipeline (and bubbles MEM/WB) while it is outstanding, abandons it after
// TIMEOUT WAIT cycles with a sticky error, and counts stall cycles.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   MemRead_i, MemWrite_i        load / store present in MEM
//   Addr_i, WriteData_i          address and store data from EX/MEM
//   mem_ack_i, mem_rdata_i       memory completion pulse and load data
//   mem_req_o, mem_we_o          registered request level and direction
//   mem_addr_o, mem_wdata_o      latched address and store data
//   stall_o, bubble_o            pipeline freeze and MEM/WB bubble
//   ReadData_o                   load result toward MEM/WB
//   err_o                        sticky timeout flag
//   stall_cnt_o                  saturating count of stalled cycles
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] Addr_i,
  input  logic [DATA_W-1:0] WriteData_i,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              stall_o,
  output logic              bubble_o,
  output logic [DATA_W-1:0] ReadData_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // The timeout counter holds the number of WAIT cycles already spent, so it
  // only ever needs to reach TIMEOUT-1.
  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              access;
  logic              issue;
  logic [TW-1:0]     tmo_cnt;

  assign access = MemRead_i | MemWrite_i;
  assign issue  = (state_q == S_IDLE) && access;

  // Stall covers the detection cycle in IDLE and every WAIT cycle; DONE lets
  // the pipeline advance so MEM/WB picks up ReadData_o exactly once.
  assign stall_o  = issue || (state_q == S_WAIT);
  assign bubble_o = stall_o;

  // Cleared on the IDLE->WAIT transition, counts while waiting.
  sat_counter #(.W(TW)) u_tmo_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (issue),
    .en_i  (state_q == S_WAIT),
    .cnt_o (tmo_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .en_i  (stall_o),
    .cnt_o (stall_cnt_o)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          // A simultaneous read+write request is issued as a write.
          mem_addr_d  = Addr_i;
          mem_wdata_d = WriteData_i;
          mem_we_d    = MemWrite_i;
          mem_req_d   = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ack is checked first so a completion on the last allowed cycle
        // is never reported as a timeout.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rdata_d = mem_rdata_i;
          end
          state_d = S_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          mem_req_d = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        // MemRead/MemWrite still show the finished instruction here.
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign ReadData_o  = rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

  localparam int TMO   = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          MemRead_i, MemWrite_i;
  logic [31:0]   Addr_i, WriteData_i;
  logic          mem_ack_i;
  logic [31:0]   mem_rdata_i;
  logic          mem_req_o, mem_we_o;
  logic [31:0]   mem_addr_o, mem_wdata_o;
  logic          stall_o, bubble_o;
  logic [31:0]   ReadData_o;
  logic          err_o;
  logic [CW-1:0] stall_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_access_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .Addr_i      (Addr_i),
    .WriteData_i (WriteData_i),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .stall_o     (stall_o),
    .bubble_o    (bubble_o),
    .ReadData_o  (ReadData_o),
    .err_o       (err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Transaction-level reference: an access is either outstanding (with the
  // number of WAIT cycles spent on it) or just finished (its completion cycle).
  bit          m_outstanding;
  int          m_waited;
  bit          m_finished;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  bit          m_err;
  int          m_cnt;

  function automatic void model_reset();
    m_outstanding = 0; m_waited = 0; m_finished = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 0; m_cnt = 0;
  endfunction

  function automatic bit model_stall();
    if (m_finished) return 1'b0;
    if (m_outstanding) return 1'b1;
    return MemRead_i | MemWrite_i;
  endfunction

  function automatic void model_clock();
    bit st;
    st = model_stall();
    m_cnt = (m_cnt + int'(st) > CMAX) ? CMAX : m_cnt + int'(st);
    if (m_finished) begin
      m_finished = 0;
    end else if (m_outstanding) begin
      m_waited++;
      if (mem_ack_i) begin
        if (!m_we) m_rdata = mem_rdata_i;
        m_outstanding = 0; m_finished = 1;
      end else if (m_waited == TMO) begin
        m_rdata = '0; m_err = 1;
        m_outstanding = 0; m_finished = 1;
      end
    end else if (MemRead_i | MemWrite_i) begin
      m_outstanding = 1; m_waited = 0;
      m_we = MemWrite_i; m_addr = Addr_i; m_wdata = WriteData_i;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("stall",    32'(stall_o),     32'(model_stall()));
    chk("bubble",   32'(bubble_o),    32'(model_stall()));
    chk("req",      32'(mem_req_o),   32'(m_outstanding));
    chk("we",       32'(mem_we_o),    32'(m_we));
    chk("addr",     mem_addr_o,       m_addr);
    chk("wdata",    mem_wdata_o,      m_wdata);
    chk("rdata",    ReadData_o,       m_rdata);
    chk("err",      32'(err_o),       32'(m_err));
    chk("stallcnt", 32'(stall_cnt_o), 32'(m_cnt));
  endtask

  // Drive one cycle's inputs after the falling edge, check, then advance the model.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic ack, input logic [31:0] rdin);
    @(negedge clk_i);
    MemRead_i = rd; MemWrite_i = wr; Addr_i = a; WriteData_i = wd;
    mem_ack_i = ack; mem_rdata_i = rdin;
    #1;
    check_all();
    model_clock();
  endtask

  typedef struct {
    logic rd, wr; logic [31:0] a, wd; logic ack; logic [31:0] rdin;
    logic e_stall, e_req, e_we; logic [31:0] e_addr, e_wdata, e_rdata; logic e_err; int e_cnt;
  } vec_t;

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] a, logic [31:0] wd, logic ack,
                              logic [31:0] rdin, logic st, logic rq, logic we, logic [31:0] ea,
                              logic [31:0] ew, logic [31:0] er, logic ee, int ec);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.ack = ack; v.rdin = rdin;
    v.e_stall = st; v.e_req = rq; v.e_we = we; v.e_addr = ea; v.e_wdata = ew;
    v.e_rdata = er; v.e_err = ee; v.e_cnt = ec;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rq_hi, pulses;
    logic prev_req;

    // Load 0x10 acked on the 1st WAIT cycle, then store 0x20 acked on the 5th.
    tbl[0]  = mk(1,0,32'h10,0,0,0,                       1,0,0,32'h0, 0,32'h0,0,0);
    tbl[1]  = mk(1,0,32'h10,0,1,32'hDEADBEEF,            1,1,0,32'h10,0,32'h0,0,1);
    tbl[2]  = mk(1,0,32'h10,0,0,0,                       0,0,0,32'h10,0,32'hDEADBEEF,0,2);
    tbl[3]  = mk(0,0,0,0,0,0,                            0,0,0,32'h10,0,32'hDEADBEEF,0,2);
    tbl[4]  = mk(0,1,32'h20,32'h12345678,0,0,            1,0,0,32'h10,0,32'hDEADBEEF,0,2);
    tbl[5]  = mk(0,1,32'h20,32'h12345678,0,0,            1,1,1,32'h20,32'h12345678,32'hDEADBEEF,0,3);
    tbl[6]  = mk(0,1,32'h20,32'h12345678,0,0,            1,1,1,32'h20,32'h12345678,32'hDEADBEEF,0,4);
    tbl[7]  = mk(0,1,32'h20,32'h12345678,0,0,            1,1,1,32'h20,32'h12345678,32'hDEADBEEF,0,5);
    tbl[8]  = mk(0,1,32'h20,32'h12345678,0,0,            1,1,1,32'h20,32'h12345678,32'hDEADBEEF,0,6);
    tbl[9]  = mk(0,1,32'h20,32'h12345678,1,32'hFFFF0000, 1,1,1,32'h20,32'h12345678,32'hDEADBEEF,0,7);
    tbl[10] = mk(0,1,32'h20,32'h12345678,0,0,            0,0,1,32'h20,32'h12345678,32'hDEADBEEF,0,8);
    tbl[11] = mk(0,0,0,0,0,0,                            0,0,1,32'h20,32'h12345678,32'hDEADBEEF,0,8);

    rst_i = 1'b0; MemRead_i = 0; MemWrite_i = 0; Addr_i = '0; WriteData_i = '0;
    mem_ack_i = 0; mem_rdata_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    #1;
    check_all();
    chk("reset_req", 32'(mem_req_o), 32'h0);
    chk("reset_cnt", 32'(stall_cnt_o), 32'h0);
    rst_i = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].ack, tbl[i].rdin);
      chk($sformatf("tbl%0d_stall", i), 32'(stall_o),     32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_req", i),   32'(mem_req_o),   32'(tbl[i].e_req));
      chk($sformatf("tbl%0d_we", i),    32'(mem_we_o),    32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_addr", i),  mem_addr_o,       tbl[i].e_addr);
      chk($sformatf("tbl%0d_wdata", i), mem_wdata_o,      tbl[i].e_wdata);
      chk($sformatf("tbl%0d_rdata", i), ReadData_o,       tbl[i].e_rdata);
      chk($sformatf("tbl%0d_err", i),   32'(err_o),       32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_cnt", i),   32'(stall_cnt_o), 32'(tbl[i].e_cnt));
    end

    // Two back-to-back loads, each acked on its first WAIT cycle.
    @(negedge clk_i); rst_i = 1'b0; MemRead_i = 0; MemWrite_i = 0; #1; model_reset(); rst_i = 1'b1;
    pulses = 0; prev_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(i < 6, 0, (i < 3) ? 32'h100 : 32'h104, 0, (i == 1) || (i == 4),
           (i < 3) ? 32'hAAAA0001 : 32'hBBBB0002);
      if (mem_req_o && !prev_req) pulses++;
      prev_req = mem_req_o;
    end
    chk("b2b_req_pulses", 32'(pulses), 32'd2);
    chk("b2b_stall_cnt", 32'(stall_cnt_o), 32'd4);
    chk("b2b_rdata", ReadData_o, 32'hBBBB0002);

    // Load that is never acked: abandoned after TMO WAIT cycles.
    rq_hi = 0;
    for (int i = 0; i < 11; i++) begin
      step(i <= 9, 0, 32'h40, 0, 0, 32'h5555AAAA);
      if (mem_req_o) rq_hi++;
    end
    chk("tmo_req_cycles", 32'(rq_hi), 32'(TMO));
    chk("tmo_err", 32'(err_o), 32'h1);
    chk("tmo_rdata", ReadData_o, 32'h0);
    chk("tmo_stall_released", 32'(stall_o), 32'h0);

    // Follow-up loads with immediate ack still complete; the count saturates.
    for (int j = 0; j < 2; j++) begin
      step(1, 0, 32'h44, 0, 0, 0);
      step(1, 0, 32'h44, 0, 1, 32'h0BAD_F00D + 32'(j));
      step(1, 0, 32'h44, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("after_tmo_rdata", ReadData_o, 32'h0BAD_F00E);
    chk("err_sticky", 32'(err_o), 32'h1);
    chk("cnt_saturated", 32'(stall_cnt_o), 32'(CMAX));

    // Read and write together are issued as a write.
    step(1, 1, 32'h60, 32'h0F0F0F0F, 0, 0);
    step(1, 1, 32'h60, 32'h0F0F0F0F, 1, 32'h77777777);
    chk("both_we", 32'(mem_we_o), 32'h1);
    step(1, 1, 32'h60, 32'h0F0F0F0F, 0, 0);
    chk("both_rdata_kept", ReadData_o, 32'h0BAD_F00E);
    step(0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of WAIT, then a stray late ack.
    step(1, 0, 32'h50, 0, 0, 0);
    step(1, 0, 32'h50, 0, 0, 0);
    @(negedge clk_i);
    MemRead_i = 0; MemWrite_i = 0; rst_i = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_async_req", 32'(mem_req_o), 32'h0);
    chk("rst_async_err", 32'(err_o), 32'h0);
    rst_i = 1'b1;
    step(0, 0, 0, 0, 1, 32'hCAFEF00D);
    step(0, 0, 0, 0, 0, 0);
    chk("late_ack_ignored", ReadData_o, 32'h0);

    // Randomized traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      int kind;
      kind = $urandom_range(0, 4);
      step(kind == 1 || kind == 3 || kind == 4, kind == 2 || kind == 4, $urandom, $urandom,
           $urandom_range(0, 99) < 18, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
